// File: rtl/lmem_rsp_merge.sv
// Regroups per-lane local-memory read responses into one warp-wide response per
// request. Responses are released strictly in slot allocation order.
module lmem_rsp_merge #(
  parameter int NUM_REQS     = 4,
  parameter int WORD_SIZE    = 4,
  parameter int NUM_SLOTS    = 4,
  parameter int TAG_WIDTH    = 16,
  // Clear to drop illegal lane responses silently instead of flagging them.
  parameter bit ASSERT_DROPS = 1'b1,
  localparam int WORD_WIDTH  = 8 * WORD_SIZE,
  localparam int SLOT_W      = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1,
  localparam int CNT_W       = $clog2(NUM_SLOTS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_valid,
  input  logic [NUM_REQS-1:0]            alloc_mask,
  input  logic [TAG_WIDTH-1:0]           alloc_tag,
  output logic                           alloc_ready,
  output logic [SLOT_W-1:0]              alloc_slot,
  input  logic [NUM_REQS-1:0]            lane_rsp_valid,
  input  logic [NUM_REQS*SLOT_W-1:0]     lane_rsp_slot,
  input  logic [NUM_REQS*WORD_WIDTH-1:0] lane_rsp_data,
  output logic [NUM_REQS-1:0]            lane_rsp_ready,
  output logic                           rsp_valid,
  output logic [NUM_REQS-1:0]            rsp_mask,
  output logic [NUM_REQS*WORD_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic                           rsp_ready
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q [NUM_SLOTS];
  logic [NUM_REQS-1:0]   pend_q  [NUM_SLOTS];
  logic [NUM_REQS-1:0]   mask_q  [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]  tag_q   [NUM_SLOTS];
  logic [WORD_WIDTH-1:0] data_q  [NUM_SLOTS][NUM_REQS];

  logic [SLOT_W-1:0]     fifo_q  [NUM_SLOTS];
  logic [SLOT_W-1:0]     head_q;
  logic [SLOT_W-1:0]     tail_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  active_q;

  logic                  any_free;
  logic [SLOT_W-1:0]     free_slot;
  logic                  alloc_fire;
  logic                  rsp_fire;
  logic [SLOT_W-1:0]     head_slot;
  logic [NUM_REQS-1:0]   hit [NUM_SLOTS];
  logic [NUM_REQS-1:0]   lane_hit;
  logic [NUM_REQS-1:0]   drop;

  // Lowest-index free slot, from registered state only.
  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (state_q[s] == ST_FREE) begin
        any_free  = 1'b1;
        free_slot = SLOT_W'(s);
      end
    end
  end

  assign alloc_ready    = active_q & any_free;
  assign alloc_slot     = free_slot;
  assign alloc_fire     = alloc_valid & alloc_ready;
  assign lane_rsp_ready = {NUM_REQS{active_q}};

  assign head_slot = fifo_q[head_q];
  assign rsp_valid = (cnt_q != '0) && (state_q[head_slot] == ST_DONE);
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign rsp_mask  = mask_q[head_slot];
  assign rsp_tag   = tag_q[head_slot];

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_data[i*WORD_WIDTH +: WORD_WIDTH] = data_q[head_slot][i];
    end
  end

  // A lane response lands only on a pending slot whose lane is still outstanding.
  always_comb begin
    lane_hit = '0;
    drop     = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      hit[s] = '0;
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (active_q && lane_rsp_valid[i] &&
            (lane_rsp_slot[i*SLOT_W +: SLOT_W] == SLOT_W'(s)) &&
            (state_q[s] == ST_PEND) && pend_q[s][i]) begin
          hit[s][i]   = 1'b1;
          lane_hit[i] = 1'b1;
        end
      end
      drop[i] = active_q & lane_rsp_valid[i] & ~lane_hit[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= ST_FREE;
        pend_q[s]  <= '0;
        mask_q[s]  <= '0;
        tag_q[s]   <= '0;
        fifo_q[s]  <= '0;
        for (int i = 0; i < NUM_REQS; i++) begin
          data_q[s][i] <= '0;
        end
      end
    end else begin
      active_q <= 1'b1;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        case (state_q[s])
          ST_FREE: begin
            if (alloc_fire && (alloc_slot == SLOT_W'(s))) begin
              state_q[s] <= (alloc_mask == '0) ? ST_DONE : ST_PEND;
              pend_q[s]  <= alloc_mask;
              mask_q[s]  <= alloc_mask;
              tag_q[s]   <= alloc_tag;
              for (int i = 0; i < NUM_REQS; i++) begin
                data_q[s][i] <= '0;
              end
            end
          end
          ST_PEND: begin
            // DONE one cycle after the last lane lands, keeping the output path registered.
            if (pend_q[s] == '0) begin
              state_q[s] <= ST_DONE;
            end
            pend_q[s] <= pend_q[s] & ~hit[s];
            for (int i = 0; i < NUM_REQS; i++) begin
              if (hit[s][i]) begin
                data_q[s][i] <= lane_rsp_data[i*WORD_WIDTH +: WORD_WIDTH];
              end
            end
          end
          ST_DONE: begin
            if (rsp_fire && (head_slot == SLOT_W'(s))) begin
              state_q[s] <= ST_FREE;
            end
          end
          default: state_q[s] <= ST_FREE;
        endcase
      end

      if (alloc_fire) begin
        fifo_q[tail_q] <= alloc_slot;
        tail_q         <= tail_q + SLOT_W'(1);
      end
      if (rsp_fire) begin
        head_q <= head_q + SLOT_W'(1);
      end
      case ({alloc_fire, rsp_fire})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ASSERT_DROPS && reset) begin
      assert (drop == '0)
        else $error("lmem_rsp_merge: dropped lane response, lanes %b", drop);
    end
  end

endmodule

// File: tb/tb_lmem_rsp_merge.sv
// Randomised bench for lmem_rsp_merge, checked every cycle against a request-level
// model (ordered queue of outstanding requests with per-lane completion tracking).
module tb_lmem_rsp_merge;

  localparam int NR = 4;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         alloc_valid = 1'b0;
  logic [3:0]   alloc_mask = '0;
  logic [15:0]  alloc_tag = '0;
  logic         alloc_ready;
  logic [1:0]   alloc_slot;
  logic [3:0]   lane_rsp_valid = '0;
  logic [7:0]   lane_rsp_slot = '0;
  logic [127:0] lane_rsp_data = '0;
  logic [3:0]   lane_rsp_ready;
  logic         rsp_valid;
  logic [3:0]   rsp_mask;
  logic [127:0] rsp_data;
  logic [15:0]  rsp_tag;
  logic         rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  lmem_rsp_merge #(
    .NUM_REQS(4), .WORD_SIZE(4), .NUM_SLOTS(4), .TAG_WIDTH(16), .ASSERT_DROPS(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_mask(alloc_mask), .alloc_tag(alloc_tag),
    .alloc_ready(alloc_ready), .alloc_slot(alloc_slot),
    .lane_rsp_valid(lane_rsp_valid), .lane_rsp_slot(lane_rsp_slot),
    .lane_rsp_data(lane_rsp_data), .lane_rsp_ready(lane_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // Request-level model: which slots hold a request, what is still outstanding,
  // and from which edge count each request may be presented.
  bit        m_active = 1'b0;
  int        edge_n = 0;
  bit        m_busy  [NS];
  bit [3:0]  m_mask  [NS];
  bit [3:0]  m_pend  [NS];
  bit [15:0] m_tag   [NS];
  bit [31:0] m_data  [NS][NR];
  int        m_ready [NS];
  int        m_order [$];

  function automatic int m_free();
    for (int s = 0; s < NS; s++) if (!m_busy[s]) return s;
    return -1;
  endfunction

  function automatic bit m_valid();
    return (m_order.size() > 0) && (edge_n >= m_ready[m_order[0]]);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      edge_n   = 0;
      m_order.delete();
      for (int s = 0; s < NS; s++) begin
        m_busy[s] = 1'b0; m_mask[s] = '0; m_pend[s] = '0; m_tag[s] = '0; m_ready[s] = 0;
        for (int i = 0; i < NR; i++) m_data[s][i] = '0;
      end
    end else if (!m_active) begin
      m_active = 1'b1;
    end else begin
      bit do_pop;
      int g;
      int s;
      do_pop = m_valid() && rsp_ready;
      g = m_free();
      edge_n++;
      for (int i = 0; i < NR; i++) begin
        if (lane_rsp_valid[i]) begin
          s = int'(lane_rsp_slot[i*2 +: 2]);
          if (m_busy[s] && m_pend[s][i]) begin
            m_data[s][i] = lane_rsp_data[i*32 +: 32];
            m_pend[s][i] = 1'b0;
            if (m_pend[s] == 4'b0000) m_ready[s] = edge_n + 1;
          end
        end
      end
      if (do_pop) begin
        m_busy[m_order[0]] = 1'b0;
        void'(m_order.pop_front());
      end
      if (alloc_valid && g >= 0) begin
        m_busy[g] = 1'b1;
        m_mask[g] = alloc_mask;
        m_pend[g] = alloc_mask;
        m_tag[g]  = alloc_tag;
        for (int i = 0; i < NR; i++) m_data[g][i] = '0;
        m_ready[g] = (alloc_mask == 4'b0000) ? edge_n : 32'h7fffffff;
        m_order.push_back(g);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
      chk("rst_alloc_ready", 128'(alloc_ready), 128'(0));
      chk("rst_lane_ready", 128'(lane_rsp_ready), 128'(0));
      chk("rst_rsp_mask", 128'(rsp_mask), 128'(0));
      chk("rst_rsp_data", rsp_data, 128'(0));
      chk("rst_rsp_tag", 128'(rsp_tag), 128'(0));
    end else begin
      logic [127:0] ed;
      int f;
      int h;
      f = m_free();
      chk("lane_ready", 128'(lane_rsp_ready), 128'({4{m_active}}));
      chk("alloc_ready", 128'(alloc_ready), 128'(m_active && f >= 0));
      if (m_active && f >= 0) chk("alloc_slot", 128'(alloc_slot), 128'(f));
      chk("rsp_valid", 128'(rsp_valid), 128'(m_valid()));
      if (m_valid()) begin
        h = m_order[0];
        for (int i = 0; i < NR; i++) ed[i*32 +: 32] = m_data[h][i];
        chk("rsp_mask", 128'(rsp_mask), 128'(m_mask[h]));
        chk("rsp_data", rsp_data, ed);
        chk("rsp_tag", 128'(rsp_tag), 128'(m_tag[h]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_lanes();
    lane_rsp_valid = '0;
    lane_rsp_slot  = '0;
    lane_rsp_data  = '0;
  endtask

  task automatic lane(input int i, input int s, input logic [31:0] d);
    lane_rsp_valid[i]        = 1'b1;
    lane_rsp_slot[i*2 +: 2]  = 2'(s);
    lane_rsp_data[i*32 +: 32] = d;
  endtask

  task automatic do_alloc(input logic [3:0] m, input logic [15:0] t);
    alloc_valid = 1'b1;
    alloc_mask  = m;
    alloc_tag   = t;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    chk("rel_alloc_slot", 128'(alloc_slot), 128'(0));
    tick();
    chk("rel_alloc_ready", 128'(alloc_ready), 128'(1));
    chk("rel_alloc_slot0", 128'(alloc_slot), 128'(0));
    chk("rel_lane_ready", 128'(lane_rsp_ready), 128'(4'hF));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_alloc_ready", 128'(alloc_ready), 128'(0));
    release_reset();

    // Single request, lanes arriving out of order.
    do_alloc(4'hF, 16'h0A5A);
    lane(0, 0, 32'h11); tick(); clr_lanes();
    lane(2, 0, 32'h33); tick(); clr_lanes();
    lane(1, 0, 32'h22); tick(); clr_lanes();
    lane(3, 0, 32'h44); tick(); clr_lanes();
    chk("t1_not_yet", 128'(rsp_valid), 128'(0));
    tick();
    chk("t1_valid", 128'(rsp_valid), 128'(1));
    chk("t1_data", rsp_data, 128'h00000044_00000033_00000022_00000011);
    chk("t1_tag", 128'(rsp_tag), 128'(16'h0A5A));
    rsp_ready = 1'b1;
    tick();
    chk("t1_popped", 128'(rsp_valid), 128'(0));

    // Younger request completes first but waits for the head.
    do_alloc(4'b0001, 16'h0001);
    do_alloc(4'b0001, 16'h0002);
    lane(0, 1, 32'hB2); tick(); clr_lanes();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_hold", 128'(rsp_valid), 128'(0));
    end
    lane(0, 0, 32'hB1); tick(); clr_lanes();
    tick();
    chk("t2_first_tag", 128'(rsp_tag), 128'(16'h0001));
    chk("t2_first_data", rsp_data, 128'h000000B1);
    tick();
    chk("t2_second_valid", 128'(rsp_valid), 128'(1));
    chk("t2_second_tag", 128'(rsp_tag), 128'(16'h0002));
    chk("t2_second_data", rsp_data, 128'h000000B2);
    tick();
    chk("t2_empty", 128'(rsp_valid), 128'(0));

    // Full with backpressure, then a single pop.
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) do_alloc(4'b0000, 16'(16'h0100 + k));
    chk("t3_full", 128'(alloc_ready), 128'(0));
    chk("t3_head_tag", 128'(rsp_tag), 128'(16'h0100));
    tick();
    chk("t3_stable_valid", 128'(rsp_valid), 128'(1));
    chk("t3_stable_tag", 128'(rsp_tag), 128'(16'h0100));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t3_freed_ready", 128'(alloc_ready), 128'(1));
    chk("t3_freed_slot", 128'(alloc_slot), 128'(0));
    chk("t3_next_tag", 128'(rsp_tag), 128'(16'h0101));
    rsp_ready = 1'b1;
    repeat (4) tick();
    chk("t3_drained", 128'(rsp_valid), 128'(0));

    // Partial mask with an illegal response on an unmasked lane, then zero mask.
    rsp_ready = 1'b0;
    do_alloc(4'b0101, 16'h0055);
    lane(0, 0, 32'hA0); lane(2, 0, 32'hA2); lane(1, 0, 32'hBAD1);
    tick(); clr_lanes();
    tick();
    chk("t4_mask", 128'(rsp_mask), 128'(4'b0101));
    chk("t4_data", rsp_data, 128'h00000000_000000A2_00000000_000000A0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    do_alloc(4'b0000, 16'h0077);
    chk("t4_zero_valid", 128'(rsp_valid), 128'(1));
    chk("t4_zero_tag", 128'(rsp_tag), 128'(16'h0077));
    chk("t4_zero_data", rsp_data, 128'(0));
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Response to a free slot and a duplicate lane response are ignored.
    do_alloc(4'b0011, 16'h0033);
    lane(0, 0, 32'hC0); lane(2, 3, 32'hDEAD); tick(); clr_lanes();
    lane(0, 0, 32'hC9); tick(); clr_lanes();
    lane(1, 0, 32'hC1); tick(); clr_lanes();
    tick();
    chk("t5_valid", 128'(rsp_valid), 128'(1));
    chk("t5_data", rsp_data, 128'h00000000_00000000_000000C1_000000C0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Reset in the middle of traffic.
    do_alloc(4'b0000, 16'h0060);
    do_alloc(4'hF, 16'h0061);
    do_alloc(4'hF, 16'h0062);
    lane(0, 1, 32'h5); lane(1, 2, 32'h6); tick(); clr_lanes();
    chk("t6_pre_tag", 128'(rsp_tag), 128'(16'h0060));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(rsp_valid), 128'(0));
    chk("t6_rst_alloc_ready", 128'(alloc_ready), 128'(0));
    chk("t6_rst_lane_ready", 128'(lane_rsp_ready), 128'(0));
    chk("t6_rst_mask", 128'(rsp_mask), 128'(0));
    chk("t6_rst_data", rsp_data, 128'(0));
    chk("t6_rst_tag", 128'(rsp_tag), 128'(0));
    release_reset();
    lane(1, 1, 32'h15); lane(2, 2, 32'h16); tick(); clr_lanes();
    chk("t6_stale_valid", 128'(rsp_valid), 128'(0));
    chk("t6_stale_slot", 128'(alloc_slot), 128'(0));
    do_alloc(4'b0010, 16'h0099);
    lane(1, 0, 32'h7); tick(); clr_lanes();
    tick();
    chk("t6_new_data", rsp_data, 128'h00000000_00000000_00000007_00000000);
    chk("t6_new_tag", 128'(rsp_tag), 128'(16'h0099));
    rsp_ready = 1'b1; tick();

    // Random traffic, biased towards legal lane responses.
    for (int c = 0; c < 3000; c++) begin
      int s;
      bit v;
      clr_lanes();
      rsp_ready   = ($urandom % 4) != 0;
      alloc_valid = ($urandom % 3) == 0;
      alloc_mask  = 4'($urandom);
      alloc_tag   = 16'($urandom);
      for (int i = 0; i < NR; i++) begin
        s = int'($urandom % NS);
        if (m_busy[s] && m_pend[s][i]) v = ($urandom % 10) < 7;
        else v = ($urandom % 10) == 0;
        if (v) lane(i, s, $urandom);
      end
      tick();
    end

    // Complete everything outstanding and drain.
    alloc_valid = 1'b0;
    rsp_ready   = 1'b1;
    for (int c = 0; c < 60; c++) begin
      clr_lanes();
      for (int i = 0; i < NR; i++)
        for (int s = 0; s < NS; s++)
          if (m_busy[s] && m_pend[s][i] && !lane_rsp_valid[i]) lane(i, s, $urandom);
      tick();
    end
    clr_lanes();
    tick();
    chk("drain_valid", 128'(rsp_valid), 128'(0));
    chk("drain_alloc_ready", 128'(alloc_ready), 128'(1));
    chk("drain_alloc_slot", 128'(alloc_slot), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lmem_rsp_merge.md
Name: lmem_rsp_merge

Overview:
- Downstream of the banked local memory. Collects the per-lane read responses that the response crossbar returns independently.
- Regroups them into one warp-wide response per originating request.
- Responses are released in allocation order, so the core sees local-memory reads complete in issue order regardless of bank conflicts.
- Upstream issue logic allocates a slot per read request and carries the slot index in the low bits of each lane's local-memory tag.

Parameters:
- NUM_REQS, 4, number of lanes (matches local memory NUM_REQS).
- WORD_SIZE, 4, bytes per lane word; WORD_WIDTH = 8*WORD_SIZE.
- NUM_SLOTS, 4, outstanding warp requests tracked; power of 2, at least 2.
- TAG_WIDTH, 16, core-side request tag returned with the merged response.
- SLOT_W = max(1, clog2(NUM_SLOTS)), derived.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- alloc_valid  in  1  upstream requests a slot for a read warp request
- alloc_mask  in  NUM_REQS  lanes that will return a response
- alloc_tag  in  TAG_WIDTH  core tag to return
- alloc_ready  out  1  a free slot exists
- alloc_slot  out  SLOT_W  slot granted; valid while alloc_ready
- lane_rsp_valid  in  NUM_REQS  per-lane local-memory response
- lane_rsp_slot  in  NUM_REQS*SLOT_W  slot index from the lane's tag
- lane_rsp_data  in  NUM_REQS*WORD_WIDTH  lane read data
- lane_rsp_ready  out  NUM_REQS  constant 1 outside reset
- rsp_valid  out  1  merged response available
- rsp_mask  out  NUM_REQS  copy of alloc_mask
- rsp_data  out  NUM_REQS*WORD_WIDTH  merged data; lanes outside the mask read 0
- rsp_tag  out  TAG_WIDTH  alloc_tag of the head request
- rsp_ready  in  1  consumer accepts

Behaviour:
- Per-slot state:
  - state: FREE, PENDING or DONE.
  - pend mask [NUM_REQS], mask, tag, data [NUM_REQS][WORD_WIDTH].
- Order FIFO: NUM_SLOTS entries of SLOT_W, with head/tail pointers and a count of width clog2(NUM_SLOTS+1).
- Reset (asynchronous assert, synchronous release):
  - all slots FREE; FIFO empty; all data registers 0.
  - rsp_valid=0, alloc_ready=0, lane_rsp_ready=0, rsp_mask/rsp_data/rsp_tag=0.
  - Asserting reset mid-operation discards everything in flight.
- Allocation:
  - alloc_ready = OR over slots of (state==FREE), using registered state only.
  - alloc_slot = lowest-index FREE slot.
  - On alloc_valid && alloc_ready: slot gets pend=alloc_mask, mask=alloc_mask, tag=alloc_tag, data cleared to 0, and the slot id is pushed to the FIFO tail.
  - The slot becomes PENDING, or DONE directly if alloc_mask==0.
- Lane responses:
  - For each lane i with lane_rsp_valid[i], the target slot s = lane_rsp_slot[i].
  - If s is PENDING and pend[i]==1: data[i] <= lane_rsp_data[i] and pend[i] <= 0.
  - Multiple lanes hitting the same slot in one cycle are all applied.
  - A slot becomes DONE the cycle after its pend mask reaches 0.
  - A response to a FREE/DONE slot, or to a lane with pend[i]==0, is dropped and flagged by a simulation-only assertion; state is unchanged.
- Output:
  - rsp_valid = FIFO non-empty && state[head]==DONE.
  - rsp_mask, rsp_data and rsp_tag come from the head slot registers, so the path is fully registered.
  - Latency: last lane response accepted at edge N -> rsp_valid high after edge N+1.
  - On rsp_valid && rsp_ready: pop the head; slot becomes FREE at the next edge.
  - Outputs hold stable while rsp_valid && !rsp_ready.
- Simultaneous events:
  - A pop and an alloc in the same cycle are both performed.
  - The slot freed by the pop is not grantable until the following cycle.
  - The FIFO can never overflow, since its count never exceeds the number of non-FREE slots.
- Ordering:
  - A DONE non-head slot waits; there is no bypass.
  - Pointer wrap-around is modulo NUM_SLOTS.
- Full condition: all slots non-FREE -> alloc_ready=0. Lane responses are still accepted.

Test Plan:
- Single request: alloc mask=4'b1111, tag=0x0A5A; lanes 0..3 respond to slot 0 in cycles 3,5,4,6 with data 0x11..0x44 -> rsp_valid rises exactly one cycle after the lane-3 response; rsp_data={0x44,0x33,0x22,0x11}, rsp_tag=0x0A5A.
- Out-of-order completion: alloc slot0 (tag 1) then slot1 (tag 2); slot1 completes first -> no rsp until slot0 completes; then tag 1 and tag 2 in back-to-back cycles with rsp_ready=1.
- Full and backpressure: fill 4 slots, hold rsp_ready=0 -> alloc_ready=0 and outputs stable. Raise rsp_ready for one cycle -> slot freed; alloc_ready=1 the next cycle with alloc_slot equal to the freed slot index.
- Partial and zero mask: mask=4'b0101 -> rsp_mask=0101 and lanes 1,3 data=0. mask=0000 -> rsp_valid one cycle after alloc.
- Illegal and duplicate: a response to a FREE slot, or a second response on an already-cleared lane -> ignored and assertion fires; merged data equals the first response.
- Reset mid-flight: 3 slots pending, drive reset low asynchronously -> all outputs 0 immediately. After release, alloc_slot=0 and later stale lane responses are ignored.
